// File: rtl/ir_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB; NOP 3, ALU/store 4, load 5 cycles.
// Strobes are held through im_ready/dm_ready wait states; IRSEQ_STALL_CNT_EN builds the stall_cnt counter.
module ir_sequencer #(
    parameter int          DataSize   = 32,
    parameter int          IMAddrSize = 10,
    parameter int          InsSize    = 64,
    parameter int unsigned IM_BASE    = 'h80
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           total_ir,
    input  logic [DataSize-1:0]   ir,
    input  logic                  im_ready,
    input  logic                  dm_ready,
    output logic [IMAddrSize-1:0] IM_address,
    output logic                  enable_im_fetch,
    output logic                  enable_dm_fetch,
    output logic                  enable_dm_write,
    output logic                  enable_reg_read,
    output logic                  enable_alu_execute,
    output logic                  enable_reg_write,
    output logic [DataSize-1:0]   present_ir,
    output logic [1:0]            mux4to1_select,
    output logic [1:0]            writeback_select,
    output logic [1:0]            alu_scr_select1,
    output logic [1:0]            alu_scr_select2,
    output logic [InsSize-1:0]    Ins_cnt,
    output logic                  exe_ir_done,
    output logic                  illegal_ir,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_pc;
    logic [DataSize-1:0] r_present_ir;
    logic [InsSize-1:0]  r_ins_cnt;
    logic                r_illegal;

    logic w_start_acc, w_latch_ir, w_retire, w_set_illegal, w_last;

    logic [5:0] w_opcode;
    logic [4:0] w_sub5;
    logic [7:0] w_sub8;
    logic w_is_basic, w_basic_ok, w_is_shift, w_is_nop;
    logic w_is_addi, w_is_ori, w_is_xori, w_is_lwi, w_is_swi, w_is_movi;
    logic w_is_ls, w_is_lw, w_is_sw, w_is_load, w_is_store, w_legal;

    assign w_opcode   = r_present_ir[31:26];
    assign w_sub5     = r_present_ir[4:0];
    assign w_sub8     = r_present_ir[7:0];
    assign w_is_basic = (w_opcode == 6'b100000);
    assign w_basic_ok = w_sub5 inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                       5'b00100, 5'b01000, 5'b01001, 5'b01011};
    assign w_is_shift = w_is_basic && (w_sub5 inside {5'b01000, 5'b01001, 5'b01011});
    // NOP is the canonical SRLI r0,r0,0 encoding
    assign w_is_nop   = w_is_basic && (w_sub5 == 5'b01001) && (r_present_ir[24:10] == 15'd0);
    assign w_is_addi  = (w_opcode == 6'b101000);
    assign w_is_ori   = (w_opcode == 6'b101100);
    assign w_is_xori  = (w_opcode == 6'b101011);
    assign w_is_lwi   = (w_opcode == 6'b000010);
    assign w_is_swi   = (w_opcode == 6'b001010);
    assign w_is_movi  = (w_opcode == 6'b100010);
    assign w_is_ls    = (w_opcode == 6'b011100);
    assign w_is_lw    = w_is_ls && (w_sub8 == 8'b0000_0010);
    assign w_is_sw    = w_is_ls && (w_sub8 == 8'b0000_1010);
    assign w_is_load  = w_is_lwi || w_is_lw;
    assign w_is_store = w_is_swi || w_is_sw;
    assign w_legal    = (w_is_basic && w_basic_ok) || w_is_addi || w_is_ori || w_is_xori ||
                        w_is_lwi || w_is_swi || w_is_movi || w_is_lw || w_is_sw;

    assign w_last     = ((r_pc + 16'd1) == total_ir);

    always_comb begin
        w_state_nxt        = r_state;
        w_start_acc        = 1'b0;
        w_latch_ir         = 1'b0;
        w_retire           = 1'b0;
        w_set_illegal      = 1'b0;
        enable_im_fetch    = 1'b0;
        enable_dm_fetch    = 1'b0;
        enable_dm_write    = 1'b0;
        enable_reg_read    = 1'b0;
        enable_alu_execute = 1'b0;
        enable_reg_write   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (total_ir == 16'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                enable_im_fetch = 1'b1;
                if (im_ready) begin
                    w_latch_ir  = 1'b1;
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                enable_reg_read = 1'b1;
                // An all-zero word is a halt marker, not an illegal instruction
                if (r_present_ir == '0) begin
                    w_state_nxt = DONE;
                end else if (!w_legal) begin
                    w_set_illegal = 1'b1;
                    w_state_nxt   = DONE;
                end else begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                enable_alu_execute = 1'b1;
                if (w_is_load || w_is_store) w_state_nxt = MEM;
                else if (w_is_nop)           w_retire    = 1'b1;
                else                         w_state_nxt = WB;
            end
            MEM: begin
                enable_dm_fetch = w_is_load;
                enable_dm_write = w_is_store;
                if (dm_ready) begin
                    if (w_is_load) w_state_nxt = WB;
                    else           w_retire    = 1'b1;
                end
            end
            WB: begin
                enable_reg_write = 1'b1;
                w_retire         = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_retire) w_state_nxt = w_last ? DONE : FETCH;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_present_ir <= '0;
            r_ins_cnt    <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_pc      <= '0;
                r_ins_cnt <= '0;
                r_illegal <= 1'b0;
            end
            if (w_latch_ir)    r_present_ir <= ir;
            if (w_set_illegal) r_illegal    <= 1'b1;
            if (w_retire) begin
                r_pc      <= r_pc + 16'd1;
                r_ins_cnt <= r_ins_cnt + InsSize'(1);
            end
        end
    end

    always_comb begin
        mux4to1_select   = 2'b00;
        writeback_select = 2'b00;
        alu_scr_select1  = 2'b00;
        alu_scr_select2  = 2'b00;
        if (w_is_shift) begin
            alu_scr_select2 = 2'b01;
        end else if (w_is_addi) begin
            mux4to1_select  = 2'b01;
            alu_scr_select2 = 2'b01;
        end else if (w_is_ori || w_is_xori || w_is_lwi || w_is_swi) begin
            mux4to1_select  = 2'b10;
            alu_scr_select2 = 2'b01;
        end else if (w_is_movi) begin
            mux4to1_select  = 2'b11;
            alu_scr_select1 = 2'b01;
            alu_scr_select2 = 2'b01;
        end
        if (w_is_load)       writeback_select = 2'b01;
        else if (w_is_store) writeback_select = 2'b10;
    end

`ifdef IRSEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == FETCH) && !im_ready) || ((r_state == MEM) && !dm_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

    assign IM_address  = IMAddrSize'(IM_BASE + 32'(r_pc));
    assign present_ir  = r_present_ir;
    assign Ins_cnt     = r_ins_cnt;
    assign illegal_ir  = r_illegal;
    assign exe_ir_done = (r_state == DONE);

endmodule

// File: tb/tb_ir_sequencer.sv
// Bench for ir_sequencer: scripted programs against a wait-state IM/DM model, expected results queued per run.
module tb_ir_sequencer;

    localparam int C_ILL = 0, C_NOP = 1, C_ALU = 2, C_LD = 3, C_ST = 4, C_ZERO = 5;

    typedef struct {
        int     lat;
        longint ins;
        int     ill;
        int     dmf, dmw, rw, rr, imf, stall;
    } res_t;

    logic        clock = 1'b0, reset = 1'b0, start = 1'b0, im_ready = 1'b0, dm_ready = 1'b0;
    logic [15:0] total_ir = '0;
    logic [31:0] ir = '0;
    logic [9:0]  IM_address;
    logic        enable_im_fetch, enable_dm_fetch, enable_dm_write;
    logic        enable_reg_read, enable_alu_execute, enable_reg_write;
    logic [31:0] present_ir;
    logic [1:0]  mux4to1_select, writeback_select, alu_scr_select1, alu_scr_select2;
    logic [63:0] Ins_cnt;
    logic        exe_ir_done, illegal_ir;
    logic [15:0] stall_cnt;

    int n_checks = 0, n_fail = 0;
    logic [31:0] prog [16];
    int im_waits = 0, dm_waits = 0, im_cnt = 0, dm_cnt = 0;
    int imf_cyc = 0, dmf_cyc = 0, dmw_cyc = 0, rw_cyc = 0, rr_cyc = 0;
    logic [9:0] addr_q [$];
    logic [7:0] sel_q  [$];
    res_t       res_q  [$];

    ir_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .total_ir(total_ir), .ir(ir),
        .im_ready(im_ready), .dm_ready(dm_ready), .IM_address(IM_address),
        .enable_im_fetch(enable_im_fetch), .enable_dm_fetch(enable_dm_fetch),
        .enable_dm_write(enable_dm_write), .enable_reg_read(enable_reg_read),
        .enable_alu_execute(enable_alu_execute), .enable_reg_write(enable_reg_write),
        .present_ir(present_ir), .mux4to1_select(mux4to1_select),
        .writeback_select(writeback_select), .alu_scr_select1(alu_scr_select1),
        .alu_scr_select2(alu_scr_select2), .Ins_cnt(Ins_cnt), .exe_ir_done(exe_ir_done),
        .illegal_ir(illegal_ir), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int cls(input logic [31:0] w);
        if (w == 32'd0) return C_ZERO;
        case (w[31:26])
            6'b100000: begin
                if (!(w[4:0] inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                     5'b00100, 5'b01000, 5'b01001, 5'b01011})) return C_ILL;
                if (w[4:0] == 5'b01001 && w[24:10] == 15'd0) return C_NOP;
                return C_ALU;
            end
            6'b101000, 6'b101100, 6'b101011, 6'b100010: return C_ALU;
            6'b000010: return C_LD;
            6'b001010: return C_ST;
            6'b011100: begin
                if (w[7:0] == 8'h02) return C_LD;
                if (w[7:0] == 8'h0A) return C_ST;
                return C_ILL;
            end
            default: return C_ILL;
        endcase
    endfunction

    // {mux4to1, writeback, alu_src1, alu_src2}
    function automatic logic [7:0] exp_sel(input logic [31:0] w);
        logic [1:0] mux, wb, a1, a2;
        mux = 2'b00; wb = 2'b00; a1 = 2'b00; a2 = 2'b00;
        case (w[31:26])
            6'b100000: if (w[4:0] inside {5'b01000, 5'b01001, 5'b01011}) a2 = 2'b01;
            6'b101000: begin mux = 2'b01; a2 = 2'b01; end
            6'b101100, 6'b101011: begin mux = 2'b10; a2 = 2'b01; end
            6'b000010: begin mux = 2'b10; a2 = 2'b01; wb = 2'b01; end
            6'b001010: begin mux = 2'b10; a2 = 2'b01; wb = 2'b10; end
            6'b100010: begin mux = 2'b11; a1 = 2'b01; a2 = 2'b01; end
            6'b011100: begin
                if (w[7:0] == 8'h02)      wb = 2'b01;
                else if (w[7:0] == 8'h0A) wb = 2'b10;
            end
            default: ;
        endcase
        return {mux, wb, a1, a2};
    endfunction

    // Memory models and strobe monitor
    always @(negedge clock) begin
        int idx;
        if (enable_im_fetch) begin
            imf_cyc++;
            if (im_cnt >= im_waits) begin
                idx      = int'(IM_address) - 'h80;
                ir       = (idx >= 0 && idx < 16) ? prog[idx] : 32'd0;
                im_ready = 1'b1;
                im_cnt   = 0;
                if (addr_q.size() > 0) check("im_addr", 64'(IM_address), 64'(addr_q.pop_front()));
                else                   check("im_fetch_extra", 1, 0);
            end else begin
                im_ready = 1'b0;
                im_cnt++;
            end
        end else begin
            im_ready = 1'b0;
            im_cnt   = 0;
        end
        if (enable_dm_fetch || enable_dm_write) begin
            if (dm_cnt >= dm_waits) begin
                dm_ready = 1'b1;
                dm_cnt   = 0;
            end else begin
                dm_ready = 1'b0;
                dm_cnt++;
            end
        end else begin
            dm_ready = 1'b0;
            dm_cnt   = 0;
        end
        if (enable_dm_fetch)  dmf_cyc++;
        if (enable_dm_write)  dmw_cyc++;
        if (enable_reg_write) rw_cyc++;
        if (enable_reg_read)  rr_cyc++;
        if (enable_alu_execute) begin
            if (sel_q.size() > 0)
                check("exec_sel", {56'd0, mux4to1_select, writeback_select, alu_scr_select1, alu_scr_select2},
                      {56'd0, sel_q.pop_front()});
            else
                check("exec_extra", 1, 0);
        end
    end

    task automatic clear_counts();
        imf_cyc = 0; dmf_cyc = 0; dmw_cyc = 0; rw_cyc = 0; rr_cyc = 0;
    endtask

    task automatic run_prog(input string name, input int n, input int imw, input int dmw);
        res_t r;
        int   c, cyc;
        r = '{default: 0};
        r.lat = 1;
        for (int i = 0; i < n; i++) begin
            c = cls(prog[i]);
            addr_q.push_back(10'('h80 + i));
            r.rr++; r.imf += 1 + imw; r.stall += imw; r.lat += imw;
            if (c == C_ILL || c == C_ZERO) begin
                r.lat += 2;
                r.ill = (c == C_ILL) ? 1 : 0;
                break;
            end
            sel_q.push_back(exp_sel(prog[i]));
            r.ins++;
            case (c)
                C_NOP:   r.lat += 3;
                C_ALU:   begin r.lat += 4; r.rw++; end
                C_LD:    begin r.lat += 5 + dmw; r.dmf += 1 + dmw; r.rw++; r.stall += dmw; end
                default: begin r.lat += 4 + dmw; r.dmw += 1 + dmw; r.stall += dmw; end
            endcase
        end
`ifndef IRSEQ_STALL_CNT_EN
        r.stall = 0;
`endif
        res_q.push_back(r);

        total_ir = 16'(n);
        im_waits = imw;
        dm_waits = dmw;
        clear_counts();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!exe_ir_done && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
        check({name, "_done"}, 64'(exe_ir_done), 1);
        r = res_q.pop_front();
        check({name, "_latency"}, 64'(cyc), 64'(r.lat));
        check({name, "_ins_cnt"}, Ins_cnt, 64'(r.ins));
        check({name, "_illegal"}, 64'(illegal_ir), 64'(r.ill));
        check({name, "_dm_fetch_cyc"}, 64'(dmf_cyc), 64'(r.dmf));
        check({name, "_dm_write_cyc"}, 64'(dmw_cyc), 64'(r.dmw));
        check({name, "_reg_write_cyc"}, 64'(rw_cyc), 64'(r.rw));
        check({name, "_reg_read_cyc"}, 64'(rr_cyc), 64'(r.rr));
        check({name, "_im_fetch_cyc"}, 64'(imf_cyc), 64'(r.imf));
        check({name, "_stall_cnt"}, 64'(stall_cnt), 64'(r.stall));
        check({name, "_fetch_left"}, 64'(addr_q.size()), 0);
        check({name, "_exec_left"}, 64'(sel_q.size()), 0);
        addr_q.delete();
        sel_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_strobes"}, {56'd0, enable_im_fetch, enable_dm_fetch, enable_dm_write, enable_reg_read,
                                   enable_alu_execute, enable_reg_write, exe_ir_done, illegal_ir}, 0);
        check({name, "_ins_cnt"}, Ins_cnt, 0);
        check({name, "_stall_cnt"}, 64'(stall_cnt), 0);
        check({name, "_present_ir"}, 64'(present_ir), 0);
        check({name, "_selects"}, {56'd0, mux4to1_select, writeback_select, alu_scr_select1, alu_scr_select2}, 0);
        check({name, "_im_address"}, 64'(IM_address), 64'h80);
    endtask

    initial begin
        int cyc;
        foreach (prog[i]) prog[i] = 32'd0;
        repeat (2) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b1;
        @(negedge clock);

        prog[0] = 32'hA0A0_0005;                      // ADDI
        run_prog("addi1", 1, 0, 0);

        prog[0] = 32'h0800_0010;                      // LWI
        prog[1] = 32'h8011_0C00;                      // ADD
        prog[2] = 32'h2800_0020;                      // SWI
        run_prog("lwi_add_swi", 3, 0, 0);

        prog[0] = 32'hA000_0001;                      // ADDI
        prog[1] = 32'hB000_00FF;                      // ORI
        run_prog("im_wait2", 2, 2, 0);

        prog[0] = 32'hFC00_0000;                      // opcode 111111
        run_prog("illegal_op", 1, 0, 0);

        prog[0] = 32'h8000_0005;                      // BASIC with unlisted sub5
        run_prog("illegal_sub5", 1, 0, 0);

        prog[0] = 32'h7000_0003;                      // LS with unlisted sub8
        run_prog("illegal_sub8", 1, 0, 0);

        run_prog("total0", 0, 0, 0);

        prog[0] = 32'h8000_0009;                      // NOP
        prog[1] = 32'h7010_0002;                      // LW
        prog[2] = 32'h7010_000A;                      // SW
        prog[3] = 32'h8800_1234;                      // MOVI
        prog[4] = 32'hAC00_0F0F;                      // XORI
        prog[5] = 32'h8010_8408;                      // SLLI
        run_prog("mix_dm_wait1", 6, 0, 1);

        prog[0] = 32'hA000_0002;                      // ADDI
        prog[1] = 32'h0000_0000;                      // halt marker
        prog[2] = 32'hA000_0003;
        run_prog("zero_halt", 3, 1, 0);

        // Reset while a store is waiting on dm_ready
        prog[0] = 32'h2800_0123;
        addr_q.push_back(10'h80);
        sel_q.push_back(exp_sel(prog[0]));
        total_ir = 16'd1;
        im_waits = 0;
        dm_waits = 1000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (!enable_dm_write && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("rst_reach_mem", 64'(enable_dm_write), 1);
        #2 reset = 1'b0;
        #1 check("rst_dm_write_drop", 64'(enable_dm_write), 0);
        check_reset_outputs("rst_mid_mem");
        @(negedge clock);
        reset = 1'b1;
        dm_waits = 0;
        clear_counts();
        repeat (4) @(negedge clock);
        check("rst_stay_idle_fetch", 64'(imf_cyc), 0);
        check("rst_stay_idle_done", 64'(exe_ir_done), 0);
        check("rst_no_retire", Ins_cnt, 0);
        addr_q.delete();
        sel_q.delete();

        prog[0] = 32'hA0A0_0005;
        run_prog("after_reset", 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
